display_scan_driver: RTL and testbench
======================================

Name: display_scan_driver

Overview:
Downstream output stage of the Fibonacci/timer top level. It takes eight per-digit descriptors produced by the counting logic and time-multiplexes them onto the Nexys A7 8-digit common-anode 7-segment display, driving the `an` and `dec_cat` pins. It provides an anti-ghosting blank guard at the start of every digit slot. Each scan frame is tear-free: all eight digits are captured in one cycle at the frame boundary.

Parameters:
NDIG, 8, number of digits scanned (1..8); an bits at index NDIG and above stay high.
SCAN_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < SCAN_DIV.

Ports:
clock  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-low reset.
digits  in  48  eight 6-bit fields; field k is digits[6k+5:6k] = {en, hex[3:0], dp}; field 0 is the rightmost digit.
an  out  8  anode enables, active-low; an[k] selects digit k.
dec_cat  out  8  cathodes, active-low; [7:1] = segments a..g, [0] = dp.
frame_tick  out  1  one-cycle pulse on the cycle the shadow capture happens.

Behaviour:
- Reset (reset=0, asynchronous): cnt=0, idx=0, shadow=0, an=8'hFF, dec_cat=8'hFF, frame_tick=0, load_pend=1.
- Prescaler cnt counts 0..SCAN_DIV-1 every cycle.
  - When cnt==SCAN_DIV-1: cnt becomes 0 and idx advances.
  - idx wraps NDIG-1 -> 0.
- Shadow capture: shadow<=digits on any edge where load_pend=1 or (cnt==SCAN_DIV-1 and idx==NDIG-1).
  - frame_tick=1 on the cycle following that edge, for exactly one cycle.
  - load_pend clears after the first capture.
  - So digits is sampled on the first clock after reset release, then once per frame.
  - digits changing mid-frame never alters the frame currently displayed.
- Output registers: an and dec_cat are registered from the current cnt/idx/shadow, so they lag the counter state by one cycle.
  - If cnt<BLANK_CYC: an=8'hFF and dec_cat=8'hFF.
  - Else if shadow field idx has en=1: an=~(1<<idx) and dec_cat={~seg7(hex), ~dp}.
  - Else (en=0): an=8'hFF and dec_cat=8'hFF. The slot time is still consumed; disabled digits are not skipped.
- seg7 (active-high, abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Encoded dec_cat values with dp off: 0->8'h03, 1->8'h9F, 8->8'h01, A->8'h11. The 8 with dp on gives 8'h00.
- At most one an bit is low in any cycle. Every slot change passes through at least BLANK_CYC cycles of an=8'hFF.
- Frame period is NDIG*SCAN_DIV cycles.
- Reset mid-slot: outputs go to 8'hFF immediately (asynchronous). After release, scanning restarts at idx=0, cnt=0, with a fresh capture.

Decomposition:
- Package disp_pkg:
  - DIG_W=6 and the field offsets EN_BIT=5, HEX_MSB=4, HEX_LSB=1, DP_BIT=0.
  - The 16-entry SEG7 constant table.
  - BLANK=8'hFF.
- Sub-module hex7seg_dec: combinational, 4-bit hex in, 7-bit active-high segments out. The driver instantiates it once on the selected shadow field.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2.
1. Reset held low with digits=all-ones -> an=8'hFF, dec_cat=8'hFF, frame_tick=0 throughout. After release, frame_tick pulses once, one cycle after the first edge.
2. digits field0={1,4'h0,0}, field1={1,4'h1,0}, others en=0 ->
   - Slot 0 shows an=8'hFE, dec_cat=8'h03 for cycles 3..8 after release.
   - Slot 1 shows an=8'hFD, dec_cat=8'h9F.
   - Slots 2..7 show an=8'hFF.
   - Frame repeats every 64 cycles.
3. Change field0 to {1,4'h8,1} mid-slot 3 -> display unchanged until after the next frame_tick; then slot 0 shows dec_cat=8'h00.
4. Scan all values 0..F in field0 across frames -> dec_cat matches the table; include A -> 8'h11.
5. Every transition: an never has two bits low. The first 2 cycles of each slot show 8'hFF.
6. Assert reset at cnt=5 of slot 4 -> an=8'hFF in the same cycle (asynchronous). After release, scanning restarts at slot 0 and frame_tick pulses once.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the 7-segment scan driver.
//   DIG_W / *_BIT   : layout of one 6-bit digit descriptor {en, hex[3:0], dp}
//   SEG7            : hex -> active-high abcdefg segment table
//   BLANK           : all-off value for active-low an / dec_cat
package disp_pkg;

  localparam int DIG_W   = 6;
  localparam int EN_BIT  = 5;
  localparam int HEX_MSB = 4;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT  = 0;

  localparam logic [7:0] BLANK = 8'hFF;

  typedef struct packed {
    logic       en;
    logic [3:0] hex;
    logic       dp;
  } dig_t;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG7 [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational hex digit to 7-segment decoder.
//   hex_i : 4-bit value 0..F
//   seg_o : active-high segments {a,b,c,d,e,f,g}
module hex7seg_dec
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7[hex_i];

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: time-multiplexes NDIG digit descriptors onto a
// common-anode 8-digit 7-segment display.
//   clock      : system clock
//   reset      : asynchronous active-low reset
//   digits     : eight 6-bit {en, hex, dp} fields, field 0 = rightmost
//   an         : active-low anode enables, an[k] selects digit k
//   dec_cat    : active-low cathodes, [7:1] = a..g, [0] = dp
//   frame_tick : one-cycle pulse after each shadow capture
module display_scan_driver
  import disp_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [47:0] digits,
  output logic [7:0]  an,
  output logic [7:0]  dec_cat,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [47:0]      shadow_q;
  logic             load_pend_q;
  logic [7:0]       an_q, an_d;
  logic [7:0]       cat_q, cat_d;
  logic             tick_q;

  logic       slot_end, capture, blank;
  dig_t       fld;
  logic [6:0] seg;

  hex7seg_dec u_dec (
    .hex_i (fld.hex),
    .seg_o (seg)
  );

  always_comb begin
    slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
    // Capture once right after reset, then only on the last cycle of the
    // last slot so a whole frame is always drawn from one snapshot.
    capture  = load_pend_q | (slot_end & (idx_q == IDX_W'(NDIG - 1)));
    blank    = (cnt_q < CNT_W'(BLANK_CYC));
    fld      = dig_t'(shadow_q[idx_q*DIG_W +: DIG_W]);

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;

    // Disabled digits still consume their slot; only the anode stays off.
    an_d  = BLANK;
    cat_d = BLANK;
    if (!blank && fld.en) begin
      an_d  = ~(8'h01 << idx_q);
      cat_d = {~seg, ~fld.dp};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      load_pend_q <= 1'b1;
      an_q        <= BLANK;
      cat_q       <= BLANK;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      if (capture) shadow_q <= digits;
      load_pend_q <= 1'b0;
      an_q        <= an_d;
      cat_q       <= cat_d;
      tick_q      <= capture;
    end
  end

  assign an         = an_q;
  assign dec_cat    = cat_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
module tb_display_scan_driver;

  localparam int NDIG   = 8;
  localparam int SDIV   = 8;
  localparam int BLK    = 2;
  localparam int FRAME  = NDIG * SDIV;

  localparam logic [6:0] SEG_TB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct {
    logic [7:0] an;
    logic [7:0] cat;
    logic       tick;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [47:0] digits;
  logic [7:0]  an, dec_cat;
  logic        frame_tick;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n;          // clock edges since reset release
  logic [47:0] shown;      // snapshot the display should be drawing
  exp_t        sb_q[$];

  display_scan_driver #(.NDIG(NDIG), .SCAN_DIV(SDIV), .BLANK_CYC(BLK)) dut (
    .clock      (clock),
    .reset      (reset),
    .digits     (digits),
    .an         (an),
    .dec_cat    (dec_cat),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] mk(input logic en, input logic [3:0] hex, input logic dp);
    return {en, hex, dp};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  // Expected output after edge k: edge k latches state cnt=(k-1)%SDIV,
  // slot=((k-1)/SDIV)%NDIG, drawn from the current snapshot.
  task automatic step();
    exp_t e;
    int   c, s, k;
    logic [5:0] f;
    k = n + 1;
    c = (k - 1) % SDIV;
    s = ((k - 1) / SDIV) % NDIG;
    f = shown[6*s +: 6];
    e.an = 8'hFF; e.cat = 8'hFF;
    if (c >= BLK && f[5]) begin
      e.an  = ~(8'h01 << s);
      e.cat = {~SEG_TB[f[4:1]], ~f[0]};
    end
    e.tick = (k == 1) || (k % FRAME == 0);
    if (e.tick) shown = digits;
    sb_q.push_back(e);
    @(posedge clock); #1;
    n++;
    e = sb_q.pop_front();
    chk("an", an, e.an);
    chk("dec_cat", dec_cat, e.cat);
    chk("frame_tick", {7'd0, frame_tick}, {7'd0, e.tick});
    chk("an_onehot", 8'($countones(~an) <= 1), 8'd1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    logic [47:0] d;

    // 1. reset held with all-ones digits
    digits = '1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("rst_an", an, 8'hFF);
      chk("rst_cat", dec_cat, 8'hFF);
      chk("rst_tick", {7'd0, frame_tick}, 8'd0);
    end

    // 2. digits 0 and 1 enabled, rest off; three frames
    d = '0;
    d[5:0]  = mk(1'b1, 4'h0, 1'b0);
    d[11:6] = mk(1'b1, 4'h1, 1'b0);
    digits = d;
    @(negedge clock);
    reset = 1'b1;
    n = 0; shown = '0;
    run(2 * FRAME);

    // 3. change inputs mid slot 3; current frame must be unaffected
    run(3 * SDIV + 4);
    d[5:0]   = mk(1'b1, 4'h8, 1'b1);
    d[35:30] = mk(1'b1, 4'hA, 1'b0);
    digits = d;
    run(FRAME - (3 * SDIV + 4) + FRAME);

    // 4. every hex value in field 0, one per frame
    d[35:30] = '0;
    for (int v = 0; v < 16; v++) begin
      d[5:0] = mk(1'b1, 4'(v), v[0]);
      digits = d;
      run(FRAME);
    end
    run(FRAME);

    // 6. reset at cnt=5 of slot 4 with digit 4 lit
    d[29:24] = mk(1'b1, 4'h3, 1'b1);
    digits = d;
    run(FRAME);
    run(4 * SDIV + 5);
    chk("pre_rst_an", an, 8'hEF);
    #2 reset = 1'b0;
    #1;
    chk("async_an", an, 8'hFF);
    chk("async_cat", dec_cat, 8'hFF);
    chk("async_tick", {7'd0, frame_tick}, 8'd0);
    repeat (3) @(posedge clock);
    #1 chk("held_an", an, 8'hFF);
    d[5:0] = mk(1'b1, 4'hA, 1'b0);
    digits = d;
    @(negedge clock);
    reset = 1'b1;
    n = 0; shown = '0;
    run(FRAME + 2 * SDIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
